// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate sweep checker: FSM states and the
// bit position of each gate within the expected/fail vectors.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   localparam int NUM_GATES = 7;

   localparam int GI_AND  = 0;
   localparam int GI_OR   = 1;
   localparam int GI_NOT  = 2;
   localparam int GI_NOR  = 3;
   localparam int GI_NAND = 4;
   localparam int GI_XOR  = 5;
   localparam int GI_XNOR = 6;

endpackage

// File: rtl/gate_sweep_checker_expect.sv
// Combinational reference model of the two-input gate block; output bits
// follow the fail_vec ordering.
module gate_expect
   import gate_chk_pkg::*;
(
   input  logic                 a,
   input  logic                 b,
   output logic [NUM_GATES-1:0] expect_vec
);

   always_comb begin
      expect_vec          = '0;
      expect_vec[GI_AND]  = a & b;
      expect_vec[GI_OR]   = a | b;
      expect_vec[GI_NOT]  = ~a;
      expect_vec[GI_NOR]  = ~(a | b);
      expect_vec[GI_NAND] = ~(a & b);
      expect_vec[GI_XOR]  = a ^ b;
      expect_vec[GI_XNOR] = ~(a ^ b);
   end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps a/b through 00,01,10,11 for LOOPS passes, lets each vector settle,
// then scores the returned gate outputs against the reference model.
module gate_sweep_checker
   import gate_chk_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int LOOPS         = 1,
   parameter int ERR_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 drv_a,
   output logic                 drv_b,
   input  logic                 and_in,
   input  logic                 or_in,
   input  logic                 not_in,
   input  logic                 nor_in,
   input  logic                 nand_in,
   input  logic                 xor_in,
   input  logic                 xnor_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [ERR_W-1:0]     err_count,
   output logic [NUM_GATES-1:0] fail_vec,
   output logic                 first_fail_valid,
   output logic [1:0]           first_fail_idx
);

   localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
   localparam int LP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;

   state_t                 state, state_nxt;
   logic [1:0]             idx;
   logic [LP_W-1:0]        loop;
   logic [SC_W-1:0]        settle_cnt;
   logic [NUM_GATES-1:0]   expect_vec;
   logic [NUM_GATES-1:0]   gate_obs;
   logic [NUM_GATES-1:0]   mismatch;
   logic                   any_mis;
   logic [ERR_W-1:0]       err_nxt;
   logic                   last_vec;
   logic                   last_loop;
   logic [1:0]             idx_nxt;

   gate_expect u_expect (
      .a          (drv_a),
      .b          (drv_b),
      .expect_vec (expect_vec)
   );

   assign gate_obs  = {xnor_in, xor_in, nand_in, nor_in, not_in, or_in, and_in};
   assign mismatch  = gate_obs ^ expect_vec;
   assign any_mis   = |mismatch;
   assign err_nxt   = (any_mis && !(&err_count)) ? err_count + 1'b1 : err_count;
   assign last_vec  = (idx == 2'd3);
   assign last_loop = (loop == LP_W'(LOOPS - 1));
   assign idx_nxt   = idx + 2'd1;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // NOTE: the default assignment first keeps this block free of inferred
   // latches on paths that do not change state.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SC_W'(1)) state_nxt = CHECK;
         CHECK:   state_nxt = (last_vec && last_loop) ? DONE : SETTLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx              <= '0;
         loop             <= '0;
         settle_cnt       <= '0;
         drv_a            <= 1'b0;
         drv_b            <= 1'b0;
         pass             <= 1'b0;
         err_count        <= '0;
         fail_vec         <= '0;
         first_fail_valid <= 1'b0;
         first_fail_idx   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               idx              <= '0;
               loop             <= '0;
               settle_cnt       <= SC_W'(SETTLE_CYCLES);
               drv_a            <= 1'b0;
               drv_b            <= 1'b0;
               pass             <= 1'b0;
               err_count        <= '0;
               fail_vec         <= '0;
               first_fail_valid <= 1'b0;
               first_fail_idx   <= '0;
            end
            SETTLE: settle_cnt <= settle_cnt - 1'b1;
            CHECK: begin
               fail_vec  <= fail_vec | mismatch;
               err_count <= err_nxt;
               if (any_mis && !first_fail_valid) begin
                  first_fail_valid <= 1'b1;
                  first_fail_idx   <= idx;
               end
               if (last_vec && last_loop) begin
                  // Final count is taken from this check, not the stale register.
                  pass <= (err_nxt == '0);
               end else begin
                  idx        <= idx_nxt;
                  settle_cnt <= SC_W'(SETTLE_CYCLES);
                  drv_a      <= idx_nxt[1];
                  drv_b      <= idx_nxt[0];
                  if (last_vec) loop <= loop + 1'b1;
               end
            end
            DONE: begin
               drv_a <= 1'b0;
               drv_b <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: three instances with different
// parameters, each driving a modelled gate block with injectable faults.
module tb_gate_sweep_checker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [2:0] start_v = '0;
   logic [2:0] drv_a_v, drv_b_v, busy_v, done_v, pass_v, ffv_v;
   logic [7:0] ec0, ec1;
   logic [1:0] ec2;
   logic [6:0] fv0, fv1, fv2;
   logic [1:0] ffi0, ffi1, ffi2;
   logic [6:0] gin0, gin1, gin2;
   logic [6:0] stuck_en [3];
   logic [6:0] stuck_val[3];
   logic [6:0] inv      [3];

   // Healthy gate block, bits ordered xnor,xor,nand,nor,not,or,and.
   function automatic logic [6:0] gates(input logic a, input logic b);
      return {~(a ^ b), a ^ b, ~(a & b), ~(a | b), ~a, a | b, a & b};
   endfunction

   assign gin0 = ((gates(drv_a_v[0], drv_b_v[0]) & ~stuck_en[0]) | (stuck_val[0] & stuck_en[0])) ^ inv[0];
   assign gin1 = ((gates(drv_a_v[1], drv_b_v[1]) & ~stuck_en[1]) | (stuck_val[1] & stuck_en[1])) ^ inv[1];
   assign gin2 = ((gates(drv_a_v[2], drv_b_v[2]) & ~stuck_en[2]) | (stuck_val[2] & stuck_en[2])) ^ inv[2];

   gate_sweep_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .drv_a(drv_a_v[0]), .drv_b(drv_b_v[0]),
      .and_in(gin0[0]), .or_in(gin0[1]), .not_in(gin0[2]), .nor_in(gin0[3]),
      .nand_in(gin0[4]), .xor_in(gin0[5]), .xnor_in(gin0[6]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(ec0),
      .fail_vec(fv0), .first_fail_valid(ffv_v[0]), .first_fail_idx(ffi0)
   );

   gate_sweep_checker #(.SETTLE_CYCLES(2), .LOOPS(3), .ERR_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .drv_a(drv_a_v[1]), .drv_b(drv_b_v[1]),
      .and_in(gin1[0]), .or_in(gin1[1]), .not_in(gin1[2]), .nor_in(gin1[3]),
      .nand_in(gin1[4]), .xor_in(gin1[5]), .xnor_in(gin1[6]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(ec1),
      .fail_vec(fv1), .first_fail_valid(ffv_v[1]), .first_fail_idx(ffi1)
   );

   gate_sweep_checker #(.SETTLE_CYCLES(2), .LOOPS(2), .ERR_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .drv_a(drv_a_v[2]), .drv_b(drv_b_v[2]),
      .and_in(gin2[0]), .or_in(gin2[1]), .not_in(gin2[2]), .nor_in(gin2[3]),
      .nand_in(gin2[4]), .xor_in(gin2[5]), .xnor_in(gin2[6]),
      .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(ec2),
      .fail_vec(fv2), .first_fail_valid(ffv_v[2]), .first_fail_idx(ffi2)
   );

   function automatic logic [7:0] ec_of(input int d);
      case (d)
         0:       return ec0;
         1:       return ec1;
         default: return {6'b0, ec2};
      endcase
   endfunction

   function automatic logic [6:0] fv_of(input int d);
      case (d)
         0:       return fv0;
         1:       return fv1;
         default: return fv2;
      endcase
   endfunction

   function automatic logic [1:0] ffi_of(input int d);
      case (d)
         0:       return ffi0;
         1:       return ffi1;
         default: return ffi2;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all_zero(input int d, input string tag);
      check({tag, "_drv"},  {30'b0, drv_a_v[d], drv_b_v[d]}, 0);
      check({tag, "_busy"}, {31'b0, busy_v[d]}, 0);
      check({tag, "_done"}, {31'b0, done_v[d]}, 0);
      check({tag, "_pass"}, {31'b0, pass_v[d]}, 0);
      check({tag, "_err"},  {24'b0, ec_of(d)}, 0);
      check({tag, "_fv"},   {25'b0, fv_of(d)}, 0);
      check({tag, "_ffv"},  {31'b0, ffv_v[d]}, 0);
      check({tag, "_ffi"},  {30'b0, ffi_of(d)}, 0);
   endtask

   // Raise start for one cycle (edge k starts that cycle) and follow the run.
   // poke: also pulse start mid-run and in the DONE cycle (left high on return).
   // abort_at: assert rst in the cycle at that offset and check the cleared state.
   task automatic run_sweep(input int d, input int lat_exp, input bit poke, input int abort_at);
      int k;
      int off;
      bit seen;
      @(negedge clk);
      start_v[d] = 1'b1;
      k = cyc;
      seen = 1'b0;
      for (int t = 0; t < 200 && !seen; t++) begin
         @(negedge clk);
         off = cyc - k;
         start_v[d] = poke && (off == 2 || off == 3);
         if (off == 1) begin
            check("run_busy_first", {31'b0, busy_v[d]}, 1);
            check("run_pass_cleared", {31'b0, pass_v[d]}, 0);
            check("run_err_cleared", {24'b0, ec_of(d)}, 0);
            check("run_fv_cleared", {25'b0, fv_of(d)}, 0);
         end
         if (off < lat_exp && (off - 1) % 3 == 1) begin
            check("run_drv", {30'b0, drv_a_v[d], drv_b_v[d]}, ((off - 1) / 3) % 4);
            check("run_no_done", {31'b0, done_v[d]}, 0);
         end
         if (abort_at != 0 && off == abort_at) begin
            check("pre_rst_err", {24'b0, ec_of(d)}, 1);
            rst = 1'b1;
            @(negedge clk);
            check_all_zero(d, "mid_rst");
            rst = 1'b0;
            start_v[d] = 1'b0;
            return;
         end
         if (done_v[d]) begin
            seen = 1'b1;
            check("done_latency", off, lat_exp);
            check("done_busy", {31'b0, busy_v[d]}, 1);
            if (poke) start_v[d] = 1'b1;
         end
      end
      if (!seen) check("done_timeout", 0, 1);
   endtask

   task automatic check_idle(input int d, input bit pass_e, input int err_e,
                             input logic [6:0] fv_e, input bit ffv_e, input logic [1:0] ffi_e);
      @(negedge clk);
      check("idle_busy", {31'b0, busy_v[d]}, 0);
      check("idle_done", {31'b0, done_v[d]}, 0);
      check("idle_drv", {30'b0, drv_a_v[d], drv_b_v[d]}, 0);
      check("pass", {31'b0, pass_v[d]}, {31'b0, pass_e});
      check("err_count", {24'b0, ec_of(d)}, err_e);
      check("fail_vec", {25'b0, fv_of(d)}, {25'b0, fv_e});
      check("first_fail_valid", {31'b0, ffv_v[d]}, {31'b0, ffv_e});
      check("first_fail_idx", {30'b0, ffi_of(d)}, {30'b0, ffi_e});
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         stuck_en[i]  = '0;
         stuck_val[i] = '0;
         inv[i]       = '0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero(0, "rst0");
      check_all_zero(1, "rst1");
      check_all_zero(2, "rst2");
      rst = 1'b0;

      // Clean sweep.
      run_sweep(0, 13, 1'b0, 0);
      check_idle(0, 1'b1, 0, 7'h00, 1'b0, 2'd0);

      // xor stuck low: fails at idx 1 and 2.
      stuck_en[0] = 7'b0100000;
      stuck_val[0] = 7'b0000000;
      run_sweep(0, 13, 1'b0, 0);
      check_idle(0, 1'b0, 2, 7'b0100000, 1'b1, 2'd1);

      // Three loops, nand stuck high: fails at idx 3 of each loop.
      stuck_en[1] = 7'b0010000;
      stuck_val[1] = 7'b0010000;
      run_sweep(1, 37, 1'b0, 0);
      check_idle(1, 1'b0, 3, 7'b0010000, 1'b1, 2'd3);

      // Two-bit counter, every gate inverted: saturates at 3.
      inv[2] = 7'h7f;
      run_sweep(2, 25, 1'b0, 0);
      check_idle(2, 1'b0, 3, 7'h7f, 1'b1, 2'd0);

      // Reset during SETTLE of idx 2, then a clean full sweep.
      run_sweep(0, 13, 1'b0, 7);
      stuck_en[0] = '0;
      run_sweep(0, 13, 1'b0, 0);
      check_idle(0, 1'b1, 0, 7'h00, 1'b0, 2'd0);

      // Stray starts in SETTLE, CHECK and DONE; restart right after DONE.
      run_sweep(0, 13, 1'b1, 0);
      run_sweep(0, 13, 1'b0, 0);
      check_idle(0, 1'b1, 0, 7'h00, 1'b0, 2'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
